g1_chain_walker: RTL

- Controller directly upstream of the G1 table search stage.
- Accepts a packet tuple plus the head index of its G1 bucket chain, then walks the linked entries through the table's search port by following next_index.
- Keeps the best (lowest ruleID) match found along the chain and returns one result per packet.
- Also arbitrates table entry writes from the update path onto the same shared search_index port.

---
 rtl/g1_chain_walker.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/g1_chain_walker.sv
// rtl/g1_chain_walker.sv - G1 bucket-chain walker and table write arbiter
//
// Walks the linked entries of one G1 bucket chain through the shared table
// search port, keeps the lowest matching ruleID, and returns one result per
// packet. Table writes from the update path share the same search_index port
// and take priority over new packets when both are pending in IDLE.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   pkt_valid/pkt_ready           packet request handshake
//   pkt_index, pkt_tuple          chain head index and packet 5-tuple
//   upd_valid/upd_ready           table write request handshake
//   upd_index, upd_data           entry to overwrite and its new contents
//   tbl_search_index              shared table index (search and write)
//   tbl_tupleData                 tuple presented to the table compare logic
//   tbl_we, tbl_din               table write strobe and write data
//   tbl_match, tbl_ruleID,        table response, valid one cycle after the
//   tbl_next_index                index is driven
//   res_valid/res_ready           result handshake
//   res_match, res_ruleID,        best match flag, lowest ruleID (NULL if none),
//   res_hops, res_truncated       lookups performed, stopped by the hop limit

module g1_chain_walker #(
    parameter int INDEX_BIT_LEN    = 11,
    parameter int PACKET_BIT_LEN   = 104,
    parameter int ENTRY_DATA_WIDTH = 171,
    parameter int MAX_HOPS         = 16,
    parameter int HOP_BIT_LEN      = 5,
    parameter logic [INDEX_BIT_LEN-1:0] NULL_INDEX = '1
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        pkt_valid,
    output logic                        pkt_ready,
    input  logic [INDEX_BIT_LEN-1:0]    pkt_index,
    input  logic [PACKET_BIT_LEN-1:0]   pkt_tuple,

    input  logic                        upd_valid,
    output logic                        upd_ready,
    input  logic [INDEX_BIT_LEN-1:0]    upd_index,
    input  logic [ENTRY_DATA_WIDTH-1:0] upd_data,

    output logic [INDEX_BIT_LEN-1:0]    tbl_search_index,
    output logic [PACKET_BIT_LEN-1:0]   tbl_tupleData,
    output logic                        tbl_we,
    output logic [ENTRY_DATA_WIDTH-1:0] tbl_din,
    input  logic                        tbl_match,
    input  logic [INDEX_BIT_LEN-1:0]    tbl_ruleID,
    input  logic [INDEX_BIT_LEN-1:0]    tbl_next_index,

    output logic                        res_valid,
    input  logic                        res_ready,
    output logic                        res_match,
    output logic [INDEX_BIT_LEN-1:0]    res_ruleID,
    output logic [HOP_BIT_LEN-1:0]      res_hops,
    output logic                        res_truncated
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [HOP_BIT_LEN-1:0] HOP_LIMIT = HOP_BIT_LEN'(MAX_HOPS);

    state_t state, state_d;

    // Walk state. The current chain index lives in tbl_search_index itself:
    // it is loaded on entry to ISSUE and nothing else touches it mid-walk.
    logic [HOP_BIT_LEN-1:0]      hops, hops_d;
    logic                        best_match, best_match_d;
    logic [INDEX_BIT_LEN-1:0]    best_rule, best_rule_d;

    logic [INDEX_BIT_LEN-1:0]    search_index_d;
    logic [PACKET_BIT_LEN-1:0]   tuple_data_d;
    logic [ENTRY_DATA_WIDTH-1:0] din_d;

    logic                        res_valid_d;
    logic                        res_match_d;
    logic [INDEX_BIT_LEN-1:0]    res_ruleID_d;
    logic [HOP_BIT_LEN-1:0]      res_hops_d;
    logic                        res_truncated_d;

    // Per-hop results computed from the table response in WAIT.
    logic                        hit;
    logic                        walk_match;
    logic [INDEX_BIT_LEN-1:0]    walk_rule;
    logic [HOP_BIT_LEN-1:0]      walk_hops;

    // Handshake readies are gated by rst so they read 0 while reset is held,
    // even though the state register already sits in IDLE.
    assign upd_ready = (state == S_IDLE) && !rst;
    assign pkt_ready = (state == S_IDLE) && !upd_valid && !rst;

    // Decoded from state so an async reset drops the write strobe at once.
    assign tbl_we    = (state == S_WRITE);

    // Strict less-than keeps the first-found entry on equal ruleIDs; a
    // matching entry whose ruleID equals NULL_INDEX can never win.
    assign hit        = tbl_match && (tbl_ruleID < best_rule);
    assign walk_match = hit ? 1'b1 : best_match;
    assign walk_rule  = hit ? tbl_ruleID : best_rule;
    assign walk_hops  = hops + HOP_BIT_LEN'(1);

    always_comb begin
        state_d         = state;
        hops_d          = hops;
        best_match_d    = best_match;
        best_rule_d     = best_rule;
        search_index_d  = tbl_search_index;
        tuple_data_d    = tbl_tupleData;
        din_d           = tbl_din;
        res_valid_d     = res_valid;
        res_match_d     = res_match;
        res_ruleID_d    = res_ruleID;
        res_hops_d      = res_hops;
        res_truncated_d = res_truncated;

        case (state)
            S_IDLE: begin
                if (upd_valid) begin
                    search_index_d = upd_index;
                    din_d          = upd_data;
                    state_d        = S_WRITE;
                end else if (pkt_valid) begin
                    hops_d       = '0;
                    best_match_d = 1'b0;
                    best_rule_d  = NULL_INDEX;
                    if (pkt_index == NULL_INDEX) begin
                        // Empty bucket: answer immediately, table untouched.
                        res_valid_d     = 1'b1;
                        res_match_d     = 1'b0;
                        res_ruleID_d    = NULL_INDEX;
                        res_hops_d      = '0;
                        res_truncated_d = 1'b0;
                        state_d         = S_DONE;
                    end else begin
                        search_index_d = pkt_index;
                        tuple_data_d   = pkt_tuple;
                        state_d        = S_ISSUE;
                    end
                end
            end

            S_WRITE: begin
                state_d = S_IDLE;
            end

            S_ISSUE: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                best_match_d = walk_match;
                best_rule_d  = walk_rule;
                hops_d       = walk_hops;
                if (tbl_next_index == NULL_INDEX || walk_hops == HOP_LIMIT) begin
                    res_valid_d     = 1'b1;
                    res_match_d     = walk_match;
                    res_ruleID_d    = walk_rule;
                    res_hops_d      = walk_hops;
                    // A NULL pointer on the last allowed hop is a clean end.
                    res_truncated_d = (tbl_next_index != NULL_INDEX);
                    state_d         = S_DONE;
                end else begin
                    search_index_d = tbl_next_index;
                    state_d        = S_ISSUE;
                end
            end

            S_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hops             <= '0;
            best_match       <= 1'b0;
            best_rule        <= NULL_INDEX;
            tbl_search_index <= '0;
            tbl_tupleData    <= '0;
            tbl_din          <= '0;
            res_valid        <= 1'b0;
            res_match        <= 1'b0;
            res_ruleID       <= NULL_INDEX;
            res_hops         <= '0;
            res_truncated    <= 1'b0;
        end else begin
            hops             <= hops_d;
            best_match       <= best_match_d;
            best_rule        <= best_rule_d;
            tbl_search_index <= search_index_d;
            tbl_tupleData    <= tuple_data_d;
            tbl_din          <= din_d;
            res_valid        <= res_valid_d;
            res_match        <= res_match_d;
            res_ruleID       <= res_ruleID_d;
            res_hops         <= res_hops_d;
            res_truncated    <= res_truncated_d;
        end
    end

endmodule
